// File: rtl/lht_pkg.sv
// Shared types for the local-history-table access scheduler: FSM states,
// pending-update entries and the history shift rule.
package lht_pkg;

  localparam int LHT_IDX_W  = 10;
  localparam int LHT_HIST_W = 10;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    UPD_WR
  } lht_state_e;

  typedef struct packed {
    logic [LHT_IDX_W-1:0] idx;
    logic                 taken;
  } lht_upd_t;

  // Newest outcome enters at the MSB; the oldest bit falls off the LSB.
  function automatic logic [LHT_HIST_W-1:0] hist_shift(input logic [LHT_HIST_W-1:0] old,
                                                       input logic                  taken);
    return {taken, old[LHT_HIST_W-1:1]};
  endfunction

endpackage

// File: rtl/lht_upd_fifo.sv
// Small synchronous FIFO holding retire-time history updates until the
// scheduler finds a free port slot for their read-modify-write.
module lht_upd_fifo
  import lht_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     push_i,
  input  lht_upd_t push_data_i,
  input  logic     pop_i,
  output lht_upd_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  lht_upd_t           mem_q [DEPTH];
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic               do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign wr_ptr_d = do_push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/lht_access_scheduler.sv
// Owns the single port of the local history SRAM: clears it after reset, then
// arbitrates prediction lookups against 2-cycle read-modify-write updates.
module lht_access_scheduler
  import lht_pkg::*;
#(
  parameter int IDX_W        = LHT_IDX_W,
  parameter int HIST_W       = LHT_HIST_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic [31:0]       lookup_pc,
  output logic              lookup_ready,
  output logic              lookup_hist_valid,
  output logic [HIST_W-1:0] lookup_hist,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  output logic              upd_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [HIST_W-1:0] mem_wdata,
  input  logic [HIST_W-1:0] mem_rdata,
  output logic              init_done
);

  localparam int               STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  lht_state_e          state_q, state_d;
  logic [IDX_W-1:0]    init_cnt_q, init_cnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                init_done_q, init_done_d;
  logic                rd_pend_q, rd_pend_d;

  lht_upd_t            push_data, head;
  logic                fifo_full, fifo_empty, pop, force_upd;

  logic                lookup_ready_raw, mem_en_raw, mem_we_raw;
  logic [IDX_W-1:0]    mem_addr_raw;
  logic [HIST_W-1:0]   mem_wdata_raw;

  logic                unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[31:IDX_W], upd_pc[31:IDX_W]};

  assign push_data.idx   = upd_pc[IDX_W-1:0];
  assign push_data.taken = upd_taken;

  lht_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (upd_valid && upd_ready),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign force_upd = fifo_full || (!fifo_empty && (starve_q >= STARVE_W'(STARVE_LIMIT)));

  always_comb begin
    state_d          = state_q;
    init_cnt_d       = init_cnt_q;
    starve_d         = starve_q;
    init_done_d      = init_done_q;
    rd_pend_d        = 1'b0;
    pop              = 1'b0;
    lookup_ready_raw = 1'b0;
    mem_en_raw       = 1'b0;
    mem_we_raw       = 1'b0;
    mem_addr_raw     = '0;
    mem_wdata_raw    = '0;

    case (state_q)
      INIT: begin
        mem_en_raw   = 1'b1;
        mem_we_raw   = 1'b1;
        mem_addr_raw = init_cnt_q;
        init_cnt_d   = init_cnt_q + IDX_W'(1);
        if (init_cnt_q == LAST_IDX) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end

      IDLE: begin
        lookup_ready_raw = !force_upd;
        if (lookup_valid && !force_upd) begin
          mem_en_raw   = 1'b1;
          mem_addr_raw = lookup_pc[IDX_W-1:0];
          rd_pend_d    = 1'b1;
          // Only lookups that overtake a waiting update count toward starvation.
          if (!fifo_empty && (starve_q < STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end else if (!fifo_empty) begin
          mem_en_raw   = 1'b1;
          mem_addr_raw = head.idx;
          starve_d     = '0;
          state_d      = UPD_WR;
        end
      end

      UPD_WR: begin
        mem_en_raw    = 1'b1;
        mem_we_raw    = 1'b1;
        mem_addr_raw  = head.idx;
        mem_wdata_raw = hist_shift(mem_rdata, head.taken);
        pop           = 1'b1;
        state_d       = IDLE;
      end

      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      starve_q    <= '0;
      init_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      starve_q    <= starve_d;
      init_done_q <= init_done_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  // Port-facing outputs are held low for as long as reset is asserted.
  assign lookup_ready      = reset && lookup_ready_raw;
  assign upd_ready         = reset && !fifo_full;
  assign mem_en            = reset && mem_en_raw;
  assign mem_we            = reset && mem_we_raw;
  assign mem_addr          = reset ? mem_addr_raw : '0;
  assign mem_wdata         = reset ? mem_wdata_raw : '0;
  assign init_done         = init_done_q;
  assign lookup_hist_valid = rd_pend_q;
  assign lookup_hist       = rd_pend_q ? mem_rdata : '0;

endmodule

// File: tb/tb_lht_access_scheduler.sv
// Directed bench for lht_access_scheduler with a behavioural single-port SRAM
// (registered read, write committed at the clock edge).
module tb_lht_access_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        lookup_ready;
  logic        lookup_hist_valid;
  logic [9:0]  lookup_hist;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_ready;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr, mem_wdata;
  logic [9:0]  mem_rdata = '0;
  logic        init_done;

  int passed = 0;
  int total  = 0;

  logic [9:0] sram [1024];

  int         wr_n;
  logic [9:0] wr_a [8];
  logic [9:0] wr_d [8];
  int         wr_c [8];

  lht_access_scheduler dut (
    .clock             (clock),
    .reset             (reset),
    .lookup_valid      (lookup_valid),
    .lookup_pc         (lookup_pc),
    .lookup_ready      (lookup_ready),
    .lookup_hist_valid (lookup_hist_valid),
    .lookup_hist       (lookup_hist),
    .upd_valid         (upd_valid),
    .upd_pc            (upd_pc),
    .upd_taken         (upd_taken),
    .upd_ready         (upd_ready),
    .mem_en            (mem_en),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .init_done         (init_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    wr_n = 0;
    for (int i = 0; i < 8; i++) begin
      wr_a[i] = '0; wr_d[i] = '0; wr_c[i] = 0;
    end
  endtask

  task automatic log_write(input int cyc);
    if (mem_en && mem_we) begin
      if (wr_n < 8) begin
        wr_a[wr_n] = mem_addr; wr_d[wr_n] = mem_wdata; wr_c[wr_n] = cyc;
      end
      wr_n++;
    end
  endtask

  function automatic int sram_nonzero();
    int n = 0;
    for (int i = 0; i < 1024; i++) if (sram[i] !== 10'h000) n++;
    return n;
  endfunction

  task automatic test_reset();
    next_cycle();
    lookup_valid = 1'b1;
    upd_valid    = 1'b1;
    #1;
    total++; if (lookup_ready !== 1'b0) $display("FAIL reset_lookup_ready: got %b want 0", lookup_ready); else passed++;
    total++; if (upd_ready !== 1'b0) $display("FAIL reset_upd_ready: got %b want 0", upd_ready); else passed++;
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset_mem_en_we: got %b%b want 00", mem_en, mem_we); else passed++;
    total++; if (mem_addr !== 10'd0 || mem_wdata !== 10'd0) $display("FAIL reset_mem_addr_wdata: got %h/%h want 0/0", mem_addr, mem_wdata); else passed++;
    total++; if (init_done !== 1'b0 || lookup_hist_valid !== 1'b0) $display("FAIL reset_done_hv: got %b%b want 00", init_done, lookup_hist_valid); else passed++;
    $display("reset: outputs held low");
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
  endtask

  task automatic test_init();
    int bad = 0;
    next_cycle();
    reset        = 1'b1;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h0000_1007;
    #1;
    for (int i = 0; i < 1024; i++) begin
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== i[9:0] || mem_wdata !== 10'h000 ||
          lookup_ready !== 1'b0 || init_done !== 1'b0) bad++;
      next_cycle();
      #1;
    end
    total++; if (bad !== 0) $display("FAIL init_sweep: got %0d bad cycles want 0", bad); else passed++;
    total++; if (init_done !== 1'b1) $display("FAIL init_done: got %b want 1", init_done); else passed++;
    total++; if (lookup_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd7)
      $display("FAIL first_lookup: got rdy=%b en=%b we=%b addr=%0d want 1 1 0 7", lookup_ready, mem_en, mem_we, mem_addr);
    else passed++;
    next_cycle();
    lookup_valid = 1'b0;
    #1;
    total++; if (lookup_hist_valid !== 1'b1 || lookup_hist !== 10'h000)
      $display("FAIL first_lookup_data: got v=%b h=%h want 1 000", lookup_hist_valid, lookup_hist);
    else passed++;
    total++; if (sram_nonzero() !== 0) $display("FAIL init_clear: got %0d nonzero entries want 0", sram_nonzero()); else passed++;
    $display("init: 1024 clear writes, first lookup accepted");
  endtask

  task automatic test_update_rmw();
    logic [2:0] tk = 3'b101;
    clear_log();
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      upd_valid = (k < 3);
      upd_pc    = 32'd1234;
      upd_taken = tk[k % 3];
      #1;
      log_write(k);
    end
    upd_valid = 1'b0;
    total++; if (wr_n !== 3) $display("FAIL rmw_count: got %0d writes want 3", wr_n); else passed++;
    total++; if (wr_a[0] !== 10'd210 || wr_a[1] !== 10'd210 || wr_a[2] !== 10'd210)
      $display("FAIL rmw_addr: got %0d %0d %0d want 210 x3", wr_a[0], wr_a[1], wr_a[2]);
    else passed++;
    total++; if (wr_d[0] !== 10'h200 || wr_d[1] !== 10'h100 || wr_d[2] !== 10'h280)
      $display("FAIL rmw_data: got %h %h %h want 200 100 280", wr_d[0], wr_d[1], wr_d[2]);
    else passed++;
    total++; if (wr_c[0] !== 2 || wr_c[1] !== 4 || wr_c[2] !== 6)
      $display("FAIL rmw_timing: got cycles %0d %0d %0d want 2 4 6", wr_c[0], wr_c[1], wr_c[2]);
    else passed++;
    next_cycle();
    lookup_valid = 1'b1;
    lookup_pc    = 32'd1234;
    #1;
    total++; if (lookup_ready !== 1'b1) $display("FAIL rmw_lookup_ready: got %b want 1", lookup_ready); else passed++;
    next_cycle();
    lookup_valid = 1'b0;
    #1;
    total++; if (lookup_hist_valid !== 1'b1 || lookup_hist !== 10'h280)
      $display("FAIL rmw_lookup_data: got v=%b h=%h want 1 280", lookup_hist_valid, lookup_hist);
    else passed++;
    $display("update_rmw: writes %h %h %h, lookup %h", wr_d[0], wr_d[1], wr_d[2], lookup_hist);
  endtask

  task automatic test_starvation();
    logic [13:0] rdy;
    clear_log();
    for (int k = 0; k < 14; k++) begin
      next_cycle();
      lookup_valid = 1'b1;
      lookup_pc    = 32'd20;
      upd_valid    = (k == 0);
      upd_pc       = 32'd30;
      upd_taken    = 1'b1;
      #1;
      rdy[k] = lookup_ready;
      log_write(k);
    end
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
    next_cycle();
    total++; if (rdy !== 14'h39FF) $display("FAIL starve_ready_seq: got %b want %b", rdy, 14'h39FF); else passed++;
    total++; if (wr_n !== 1 || wr_a[0] !== 10'd30 || wr_d[0] !== 10'h200 || wr_c[0] !== 10)
      $display("FAIL starve_write: got n=%0d a=%0d d=%h c=%0d want 1 30 200 10", wr_n, wr_a[0], wr_d[0], wr_c[0]);
    else passed++;
    $display("starvation: ready pattern %b", rdy);
  endtask

  task automatic test_hazard();
    logic rdy2, rdy3, we2;
    logic [9:0] addr3;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      upd_valid    = (k == 0);
      upd_pc       = 32'd5;
      upd_taken    = 1'b1;
      lookup_valid = (k == 2 || k == 3);
      lookup_pc    = 32'd5;
      #1;
      if (k == 2) begin rdy2 = lookup_ready; we2 = mem_we; end
      if (k == 3) begin rdy3 = lookup_ready; addr3 = mem_addr; end
    end
    upd_valid    = 1'b0;
    lookup_valid = 1'b0;
    total++; if (rdy2 !== 1'b0 || we2 !== 1'b1) $display("FAIL hazard_updwr: got rdy=%b we=%b want 0 1", rdy2, we2); else passed++;
    total++; if (rdy3 !== 1'b1 || addr3 !== 10'd5) $display("FAIL hazard_issue: got rdy=%b addr=%0d want 1 5", rdy3, addr3); else passed++;
    total++; if (lookup_hist_valid !== 1'b1 || lookup_hist !== 10'h200)
      $display("FAIL hazard_data: got v=%b h=%h want 1 200", lookup_hist_valid, lookup_hist);
    else passed++;
    $display("hazard: lookup after write returned %h", lookup_hist);
  endtask

  task automatic test_fifo_full_init();
    logic [4:0] rdy;
    logic [4:0] tk = 5'b11101;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      upd_valid = 1'b1;
      upd_pc    = (k == 4) ? 32'd9 : 32'(k + 1);
      upd_taken = tk[k];
      #1;
      rdy[k] = upd_ready;
      next_cycle();
    end
    upd_valid = 1'b0;
    total++; if (rdy !== 5'b01111) $display("FAIL full_upd_ready: got %b want 01111", rdy); else passed++;
    for (int n = 0; n < 1100 && init_done !== 1'b1; n++) next_cycle();
    lookup_valid = 1'b1;
    lookup_pc    = 32'd50;
    #1;
    total++; if (init_done !== 1'b1) $display("FAIL full_init_done: got %b want 1", init_done); else passed++;
    total++; if (lookup_ready !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd1)
      $display("FAIL full_priority: got rdy=%b en=%b we=%b addr=%0d want 0 1 0 1", lookup_ready, mem_en, mem_we, mem_addr);
    else passed++;
    clear_log();
    for (int j = 1; j < 10; j++) begin
      next_cycle();
      lookup_valid = 1'b0;
      #1;
      log_write(j);
    end
    total++; if (wr_n !== 4) $display("FAIL full_drain_count: got %0d want 4", wr_n); else passed++;
    total++; if (wr_a[0] !== 10'd1 || wr_a[1] !== 10'd2 || wr_a[2] !== 10'd3 || wr_a[3] !== 10'd4)
      $display("FAIL full_drain_order: got %0d %0d %0d %0d want 1 2 3 4", wr_a[0], wr_a[1], wr_a[2], wr_a[3]);
    else passed++;
    total++; if (wr_d[0] !== 10'h200 || wr_d[1] !== 10'h000 || wr_d[2] !== 10'h200 || wr_d[3] !== 10'h200)
      $display("FAIL full_drain_data: got %h %h %h %h want 200 000 200 200", wr_d[0], wr_d[1], wr_d[2], wr_d[3]);
    else passed++;
    total++; if (wr_c[0] !== 1 || wr_c[3] !== 7) $display("FAIL full_drain_timing: got %0d..%0d want 1..7", wr_c[0], wr_c[3]); else passed++;
    $display("fifo_full_init: upd_ready %b, drained %0d entries", rdy, wr_n);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    logic we4;
    logic [9:0] addr4;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      upd_valid = (k < 4);
      upd_pc    = 32'(100 + k);
      upd_taken = 1'b1;
      #1;
      if (k == 4) begin we4 = mem_we; addr4 = mem_addr; end
    end
    upd_valid = 1'b0;
    total++; if (we4 !== 1'b1 || addr4 !== 10'd101) $display("FAIL midrst_updwr: got we=%b addr=%0d want 1 101", we4, addr4); else passed++;
    #1;
    reset = 1'b0;
    #1;
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 10'd0)
      $display("FAIL midrst_mem: got en=%b we=%b a=%h d=%h want all 0", mem_en, mem_we, mem_addr, mem_wdata);
    else passed++;
    total++; if (lookup_ready !== 1'b0 || upd_ready !== 1'b0 || init_done !== 1'b0 || lookup_hist_valid !== 1'b0)
      $display("FAIL midrst_ctrl: got %b%b%b%b want 0000", lookup_ready, upd_ready, init_done, lookup_hist_valid);
    else passed++;
    next_cycle();
    reset = 1'b1;
    #1;
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd0)
      $display("FAIL midrst_reinit: got en=%b we=%b addr=%0d want 1 1 0", mem_en, mem_we, mem_addr);
    else passed++;
    for (int n = 0; n < 1060; n++) begin
      if (mem_en && mem_we && mem_wdata !== 10'h000) bad++;
      next_cycle();
      #1;
    end
    total++; if (bad !== 0) $display("FAIL midrst_stale_writes: got %0d want 0", bad); else passed++;
    total++; if (sram_nonzero() !== 0) $display("FAIL midrst_table: got %0d nonzero entries want 0", sram_nonzero()); else passed++;
    total++; if (init_done !== 1'b1) $display("FAIL midrst_done: got %b want 1", init_done); else passed++;
    $display("reset_mid: queued updates dropped, table re-cleared");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = 10'h155;
    test_reset();
    test_init();
    test_update_rmw();
    test_starvation();
    test_hazard();
    test_fifo_full_init();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lht_access_scheduler.md
Name: lht_access_scheduler

Overview:
- Owns the single read/write port of the tournament predictor's local history SRAM (1024 x 10-bit entries, indexed by pc[9:0]).
- Arbitrates between front-end prediction lookups and retire-time history updates.
- Each update is a 2-cycle read-modify-write: shift the history right and insert the outcome at the MSB.
- After reset, sequences a clear of every entry before accepting lookups.

Parameters:
IDX_W, 10, table index width; table depth = 2**IDX_W
HIST_W, 10, history bits per entry
FIFO_DEPTH, 4, pending-update queue depth (power of 2, >= 2)
STARVE_LIMIT, 8, consecutive lookup wins allowed while updates are pending

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
lookup_valid  in  1  prediction lookup request
lookup_pc  in  32  lookup PC; index = lookup_pc[IDX_W-1:0]
lookup_ready  out  1  lookup accepted this cycle when valid&ready
lookup_hist_valid  out  1  lookup result valid
lookup_hist  out  HIST_W  history read for the accepted lookup
upd_valid  in  1  resolved-branch update request
upd_pc  in  32  update PC; index = upd_pc[IDX_W-1:0]
upd_taken  in  1  branch outcome
upd_ready  out  1  update queue has space
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM write enable
mem_addr  out  IDX_W  SRAM index
mem_wdata  out  HIST_W  SRAM write data
mem_rdata  in  HIST_W  SRAM read data, valid the cycle after a read
init_done  out  1  table clear complete

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM=INIT, init counter=0, FIFO empty, starve counter=0.
  - All outputs 0, including lookup_ready, upd_ready, init_done, mem_*.
  - Reset asserted mid-operation drops queued and in-flight updates; no partial write is issued after reset deasserts.
- FSM states INIT, IDLE, UPD_WR.
- INIT:
  - Each cycle: mem_en=1, mem_we=1, mem_addr=init counter, mem_wdata=0; counter increments.
  - After writing index 2**IDX_W-1 -> IDLE; init_done=1 from the next cycle and stays 1 until reset.
  - lookup_ready=0 throughout INIT.
  - upd_ready = !fifo_full, so updates may enqueue during INIT.
- IDLE arbitration, one port op per cycle:
  - force_upd = fifo_full OR (fifo nonempty AND starve_cnt >= STARVE_LIMIT).
  - lookup_ready = !force_upd.
  - If lookup_valid and !force_upd: read issued (mem_en=1, mem_we=0, mem_addr=lookup index).
    - Next cycle: lookup_hist_valid=1, lookup_hist=mem_rdata; both are 0 otherwise.
    - starve_cnt increments (saturating) if the FIFO is nonempty.
  - Else if FIFO nonempty: read of the head index issued -> UPD_WR; starve_cnt cleared.
  - Else: port idle.
- UPD_WR (one cycle):
  - Writes head index with mem_wdata = {head.taken, mem_rdata[HIST_W-1:1]}.
  - Pops the FIFO -> IDLE; lookup_ready=0.
  - Update latency from FIFO head to write = 2 cycles.
- FIFO:
  - Entries {idx, taken}.
  - upd_ready = !full; simultaneous push and pop is legal in any state, including when full only if upd_ready was high.
  - Ordering is strict FIFO, so back-to-back updates to the same index compound correctly.
- Hazards:
  - A lookup issued the cycle after UPD_WR to the same index returns the new value (SRAM write committed at the edge).
  - A lookup does not forward from queued updates; stale reads are architecturally acceptable.
- lookup_ready depends combinationally on state and FIFO status only, never on lookup_valid.

Decomposition:
- Package lht_pkg:
  - IDX_W and HIST_W defaults.
  - Enum lht_state_e {INIT, IDLE, UPD_WR}.
  - Struct lht_upd_t {idx[IDX_W-1:0], taken}.
  - Function hist_shift(old, taken).
- Sub-module lht_upd_fifo: parameterized synchronous FIFO of lht_upd_t with full/empty, asynchronous active-low reset.
- Arbitration, FSM and init counter stay in lht_access_scheduler.

Test Plan:
- Release reset, hold lookup_valid=1 -> lookup_ready=0 for 1024 cycles with writes of 0 to addresses 0..1023, then init_done=1 and the first lookup is accepted.
- After init, updates for pc=1234 (idx 210) with taken=1, then 0, then 1 -> writes 0x200, 0x100, 0x280; a subsequent lookup of pc=1234 returns 0x280 one cycle after acceptance.
- Continuous lookup_valid with one queued update -> exactly 8 lookups accepted, then lookup_ready=0 for 2 cycles while the RMW runs, then lookups resume.
- 4 updates enqueued during INIT -> upd_ready=0 on the 5th; after init the FIFO drains in order ahead of lookups (full forces priority) at 2 cycles each.
- Update of idx 5 enters UPD_WR, then a lookup of idx 5 is issued next cycle -> the new history is returned, not the old.
- Assert reset during UPD_WR with 3 entries queued -> all outputs 0 immediately; after release the FSM re-runs INIT and the queued updates are never written.
